// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
  localparam int IFU_ADDR_W = 32;
  localparam logic [IFU_ADDR_W-1:0] PC_STEP = IFU_ADDR_W'(4);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} ifu_state_t;
  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [31:0]           instr;
  } ifu_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// ifu_queue: small synchronous FIFO with flush, used for fetched instructions and PC tags
module ifu_queue #(
  parameter int Depth = 2,
  parameter int Width = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [Width-1:0]             din,
  output logic [Width-1:0]             dout,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction
  // Storage, pointers and occupancy; flush empties the FIFO and wins over pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout  = mem[rd_ptr];
  assign full  = count == CW'(Depth);
  assign empty = count == '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch PC owner, credit-limited memory requester and decode queue; IFU_ALIGN_TRAP_EN adds align_fault and HALT
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [IFU_ADDR_W-1:0] ResetPc    = '0,
  parameter int                    QueueDepth = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [IFU_ADDR_W-1:0] mem_address,
  input  logic                  mem_gnt,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           out_instruction,
  output logic [IFU_ADDR_W-1:0] out_pc,
  input  logic                  redirect_valid,
  input  logic [IFU_ADDR_W-1:0] redirect_target
`ifdef IFU_ALIGN_TRAP_EN
  ,
  output logic                  align_fault
`endif
);
  localparam int CW = $clog2(QueueDepth + 1);
  ifu_state_t state, state_nxt;
  logic [IFU_ADDR_W-1:0] fetch_pc, tag;
  logic [CW-1:0] outstanding, discard, discard_nxt, q_count, t_count;
  logic [CW:0] credit;
  logic gnt, rsp, pop, push, redir, bad_align, q_flush, q_full, q_empty, t_full, t_empty;
  ifu_entry_t q_dout;
  logic unused;
  assign gnt   = mem_req & mem_gnt;
  assign rsp   = mem_rd_valid;
  assign pop   = instr_valid & instr_ready;
  assign redir = redirect_valid & (state == RUN || state == FLUSH);
`ifdef IFU_ALIGN_TRAP_EN
  assign bad_align = redir & (redirect_target[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif
  // A slot being popped this cycle is free again, which sustains one instruction per cycle
  assign credit = (CW+1)'(outstanding) + (CW+1)'(q_count) - (CW+1)'(pop);
  // On redirect every request still in flight (including one granted now) becomes stale
  assign discard_nxt = redir ? outstanding + CW'(gnt) - CW'(rsp)
                     : (rsp && discard != '0) ? discard - CW'(1) : discard;
  assign mem_address     = fetch_pc;
  assign instr_valid     = ~q_empty;
  assign out_instruction = q_dout.instr;
  assign out_pc          = q_dout.pc;
  assign unused          = ^{t_count, t_full, t_empty, q_full};
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // Next state: stay flushing while stale responses remain; HALT is sticky until reset
  always_comb begin
    state_nxt = (state == IDLE) ? RUN
              : (state == HALT || bad_align) ? HALT
              : (discard_nxt != '0) ? FLUSH : RUN;
  end
  // FSM outputs: request gating, queue push and queue flush
  always_comb begin
    mem_req = (state == RUN) && (credit < (CW+1)'(QueueDepth));
    push    = rsp && discard == '0 && !redir && state != HALT;
    q_flush = redir || state == HALT;
  end
  // Fetch PC, outstanding-request count and stale-response count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= ResetPc;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= redir ? redirect_target & ~IFU_ADDR_W'(3) : gnt ? fetch_pc + PC_STEP : fetch_pc;
      outstanding <= outstanding + CW'(gnt) - CW'(rsp);
      discard     <= discard_nxt;
    end
  end
`ifdef IFU_ALIGN_TRAP_EN
  // Sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_fault <= 1'b0;
    else align_fault <= align_fault | bad_align;
  end
`endif
  ifu_queue #(.Depth(QueueDepth), .Width($bits(ifu_entry_t))) u_iq (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(q_flush),
    .din({tag, mem_rd_data}), .dout(q_dout), .count(q_count), .full(q_full), .empty(q_empty)
  );
  ifu_queue #(.Depth(QueueDepth), .Width(IFU_ADDR_W)) u_tag (
    .clk(clk), .rst_n(rst_n), .push(gnt), .pop(rsp), .flush(1'b0),
    .din(fetch_pc), .dout(tag), .count(t_count), .full(t_full), .empty(t_empty)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: table vectors plus scoreboarded fetch stream against a variable-latency memory
module tb_instruction_fetch_unit;
  logic clk, rst_n;
  logic mem_req, mem_gnt, mem_rd_valid, instr_valid, instr_ready, redirect_valid;
  logic [31:0] mem_address, mem_rd_data, out_instruction, out_pc, redirect_target;
  logic w_req, w_rd_valid, w_valid;
  logic [31:0] w_address, w_rd_data, w_instr, w_pc;
`ifdef IFU_ALIGN_TRAP_EN
  logic align_fault, w_align_fault;
`endif

  instruction_fetch_unit #(.ResetPc(32'h0), .QueueDepth(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_address(mem_address), .mem_gnt(mem_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .out_instruction(out_instruction), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
`ifdef IFU_ALIGN_TRAP_EN
    , .align_fault(align_fault)
`endif
  );

  instruction_fetch_unit #(.ResetPc(32'hFFFF_FFF8), .QueueDepth(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .mem_req(w_req), .mem_address(w_address), .mem_gnt(1'b1),
    .mem_rd_valid(w_rd_valid), .mem_rd_data(w_rd_data), .instr_valid(w_valid),
    .instr_ready(1'b1), .out_instruction(w_instr), .out_pc(w_pc),
    .redirect_valid(1'b0), .redirect_target(32'h0)
`ifdef IFU_ALIGN_TRAP_EN
    , .align_fault(w_align_fault)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { bit gnt; bit rdy; bit req; logic [31:0] addr; bit valid; logic [31:0] pc; } vec_t;

  pend_t pend[$];
  logic [63:0] sb[$];
  logic [31:0] w_seen[$];
  int total = 0, bad = 0, cyc = 0, lat = 1, gnt_cnt = 0;
  logic [31:0] exp_pc, last_gnt, prev_addr, w_addr;
  logic prev_stall, w_pend;
  logic obs_req, obs_valid, obs_fault;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit gnt, input bit rdy, input bit redir = 0, input logic [31:0] tgt = 0);
    logic [63:0] e;
    mem_gnt = gnt; instr_ready = rdy; redirect_valid = redir; redirect_target = tgt;
    mem_rd_valid = 0; mem_rd_data = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rd_valid = 1; mem_rd_data = f(pend[0].addr); void'(pend.pop_front());
    end
    w_rd_valid = w_pend; w_rd_data = f(w_addr);
    #1;
    obs_req = mem_req; obs_addr = mem_address; obs_valid = instr_valid; obs_pc = out_pc;
`ifdef IFU_ALIGN_TRAP_EN
    obs_fault = align_fault;
`else
    obs_fault = 0;
`endif
    if (prev_stall && mem_req) chk("hold_addr", mem_address, prev_addr);
    prev_stall = mem_req && !gnt; prev_addr = mem_address;
    if (instr_valid && rdy) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_delivery: got pc %h want none (cycle %0d)", out_pc, cyc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e[63:32]);
        chk("out_instr", out_instruction, e[31:0]);
      end
    end
    if (mem_req && gnt) begin
      gnt_cnt++; last_gnt = mem_address;
      pend.push_back('{mem_address, cyc + lat});
      if (!redir) begin
        chk("fetch_addr", mem_address, exp_pc);
        sb.push_back({mem_address, f(mem_address)});
        exp_pc += 4;
      end
    end
    if (redir) begin sb.delete(); exp_pc = tgt & ~32'h3; end
    total++;
    if (sb.size() > 2) begin
      bad++;
      $display("FAIL credit: got %0d in flight want <=2 (cycle %0d)", sb.size(), cyc);
    end
    if (w_valid) w_seen.push_back(w_pc);
    w_pend = w_req; w_addr = w_address;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int l);
    rst_n = 0;
    mem_gnt = 0; instr_ready = 0; redirect_valid = 0; redirect_target = 0;
    mem_rd_valid = 0; mem_rd_data = 0; w_rd_valid = 0; w_rd_data = 0;
    pend.delete(); sb.delete(); w_seen.delete();
    w_pend = 0; w_addr = 0; prev_stall = 0; lat = l; exp_pc = 0; gnt_cnt = 0; last_gnt = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instruction, 0);
    chk("rst_w_addr", w_address, 32'hFFFF_FFF8);
`ifdef IFU_ALIGN_TRAP_EN
    chk("rst_fault", align_fault, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    logic [31:0] a0;
    int n0;
    bit found;
    vt[0] = '{1, 1, 0, 32'h00, 0, 32'h0};
    vt[1] = '{1, 1, 1, 32'h00, 0, 32'h0};
    vt[2] = '{1, 1, 1, 32'h04, 0, 32'h0};
    vt[3] = '{1, 1, 1, 32'h08, 1, 32'h0};
    vt[4] = '{1, 1, 1, 32'h0C, 1, 32'h4};
    vt[5] = '{1, 1, 1, 32'h10, 1, 32'h8};
    vt[6] = '{1, 1, 1, 32'h14, 1, 32'hC};
    rst_n = 0;
    @(negedge clk);

    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      cycle(vt[i].gnt, vt[i].rdy);
      chk("v_req", obs_req, vt[i].req);
      chk("v_addr", obs_addr, vt[i].addr);
      chk("v_valid", obs_valid, vt[i].valid);
      if (vt[i].valid) chk("v_pc", obs_pc, vt[i].pc);
    end
    for (int i = 0; i < 4; i++) cycle(1, 1);
    if (w_seen.size() < 3) chk("wrap_count", w_seen.size(), 3);
    else begin
      chk("wrap0", w_seen[0], 32'hFFFF_FFF8);
      chk("wrap1", w_seen[1], 32'hFFFF_FFFC);
      chk("wrap2", w_seen[2], 32'h0000_0000);
    end

    do_reset(1);
    for (int i = 0; i < 8; i++) cycle(1, 0);
    chk("bp_grants", gnt_cnt, 2);
    chk("bp_req", obs_req, 0);
    cycle(1, 1);
    chk("bp_valid0", obs_valid, 1);
    chk("bp_pc0", obs_pc, 32'h0);
    chk("bp_resume_req", obs_req, 1);
    chk("bp_resume_addr", obs_addr, 32'h8);
    cycle(1, 1);
    chk("bp_pc1", obs_pc, 32'h4);
    for (int i = 0; i < 3; i++) cycle(1, 1);

    cycle(0, 1);
    a0 = obs_addr;
    chk("stall_req0", obs_req, 1);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1);
      chk("stall_req", obs_req, 1);
      chk("stall_addr", obs_addr, a0);
    end
    cycle(1, 1);
    chk("stall_release", obs_addr, a0);
    for (int i = 0; i < 4; i++) cycle(1, 1);

    do_reset(3);
    for (int i = 0; i < 3; i++) cycle(1, 1);
    cycle(1, 1, 1, 32'h100);
    chk("rd_req_full", obs_req, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1);
      chk("flush_req", obs_req, 0);
      chk("flush_valid", obs_valid, 0);
    end
    cycle(1, 1);
    chk("rd_req", obs_req, 1);
    chk("rd_addr", obs_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1, 1);
      if (obs_valid) begin found = 1; chk("rd_first_pc", obs_pc, 32'h100); end
    end
    if (!found) chk("rd_first_valid", 0, 1);

    do_reset(1);
    for (int i = 0; i < 6; i++) cycle(1, 1);
    cycle(1, 1, 1, 32'h102);
`ifdef IFU_ALIGN_TRAP_EN
    cycle(1, 1);
    chk("align_fault", obs_fault, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1);
      chk("halt_req", obs_req, 0);
      chk("halt_valid", obs_valid, 0);
      chk("halt_fault", obs_fault, 1);
    end
`else
    n0 = gnt_cnt;
    for (int i = 0; i < 10 && gnt_cnt == n0; i++) cycle(1, 1);
    chk("align_grant", gnt_cnt, n0 + 1);
    chk("align_addr", last_gnt, 32'h100);
    chk("align_nofault", obs_fault, 0);
`endif
    for (int i = 0; i < 4; i++) cycle(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
